// File: rtl/ila_core_sync_if.sv
// Register-side bus of the ILA capture core: trigger configuration, soft clear and sample readback.
// Master is the register wrapper; slave is ila_core_sync.
interface ila_core_sync_if #(
    parameter int DATA_W    = 32,
    parameter int BUFFER_W  = 8,
    parameter int TRIGGER_W = 1,
    parameter int VS_W      = 1
);
    logic                 rst_soft;
    logic [TRIGGER_W-1:0] trigger_type;
    logic [TRIGGER_W-1:0] negate_trigger;
    logic [TRIGGER_W-1:0] trigger_mask;
    logic                 delay_trigger;
    logic                 delay_signal;
    logic                 reduce_type;
    logic [BUFFER_W-1:0]  index;
    logic [VS_W-1:0]      value_select;
    logic [DATA_W-1:0]    samples;
    logic [DATA_W-1:0]    value;

    modport master (
        output rst_soft, trigger_type, negate_trigger, trigger_mask,
               delay_trigger, delay_signal, reduce_type, index, value_select,
        input  samples, value
    );

    modport slave (
        input  rst_soft, trigger_type, negate_trigger, trigger_mask,
               delay_trigger, delay_signal, reduce_type, index, value_select,
        output samples, value
    );
endinterface

// File: rtl/ila_core_sync.sv
// ILA capture core: stores the (optionally delayed) debug vector while the masked, reduced trigger is active.
// Optional macro ILA_CIRCULAR_EN: when defined, a full buffer wraps and overwrites the oldest entries.
module ila_core_sync #(
    parameter int DATA_W    = 32,
    parameter int BUFFER_W  = 8,
    parameter int SIGNAL_W  = 8,
    parameter int TRIGGER_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SIGNAL_W-1:0]  signal,
    input  logic [TRIGGER_W-1:0] trigger,
    ila_core_sync_if.slave       bus
);
    localparam int NSLICE = (SIGNAL_W + DATA_W - 1) / DATA_W;
    localparam int VS_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int ROW_W  = (2 ** VS_W) * DATA_W;
    localparam int DEPTH  = 2 ** BUFFER_W;

    logic [TRIGGER_W-1:0] t_now;
    logic [TRIGGER_W-1:0] t_p0;
    logic [TRIGGER_W-1:0] t_use;
    logic [TRIGGER_W-1:0] latch_q;
    logic [TRIGGER_W-1:0] act_bits;
    logic [SIGNAL_W-1:0]  sig_p0;
    logic [SIGNAL_W-1:0]  d_use;
    logic [BUFFER_W:0]    count;
    logic [BUFFER_W-1:0]  wr_ptr;
    logic [SIGNAL_W-1:0]  mem [DEPTH];
    logic [ROW_W-1:0]     row;
    logic [DATA_W-1:0]    value_q;
    logic                 clr;
    logic                 active;
    logic                 full;
    logic                 wr_en;

    // An all-zero mask never fires, regardless of the reduction mode.
    function automatic logic reduce_trig(input logic [TRIGGER_W-1:0] a,
                                         input logic [TRIGGER_W-1:0] mask,
                                         input logic                 and_mode);
        if (mask == '0)
            return 1'b0;
        return and_mode ? &(a | ~mask) : |(a & mask);
    endfunction

    assign clr      = rst | bus.rst_soft;
    assign t_now    = trigger ^ bus.negate_trigger;
    assign t_use    = bus.delay_trigger ? t_p0 : t_now;
    assign act_bits = t_use | (latch_q & ~bus.trigger_type);
    assign active   = reduce_trig(act_bits, bus.trigger_mask, bus.reduce_type);
    assign d_use    = bus.delay_signal ? sig_p0 : signal;
    // count saturates at DEPTH, so its MSB alone flags a full buffer.
    assign full     = count[BUFFER_W];

`ifdef ILA_CIRCULAR_EN
    assign wr_en = active & ~clr;
`else
    assign wr_en = active & ~full & ~clr;
`endif

    // Stage p0: trigger/signal delay registers, sticky latches and write bookkeeping.
    always_ff @(posedge clk) begin
        if (clr) begin
            count   <= '0;
            wr_ptr  <= '0;
            latch_q <= '0;
            t_p0    <= '0;
            sig_p0  <= '0;
        end else begin
            t_p0    <= t_now;
            sig_p0  <= signal;
            latch_q <= latch_q | (t_use & ~bus.trigger_type);
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!full)
                    count <= count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= d_use;
    end

    // Stage p1: registered readback; slices past SIGNAL_W come from the zero padding of row.
    assign row = ROW_W'(mem[bus.index]);

    always_ff @(posedge clk) begin
        if (rst)
            value_q <= '0;
        else
            value_q <= row[bus.value_select * DATA_W +: DATA_W];
    end

    assign bus.samples = DATA_W'(count);
    assign bus.value   = value_q;
endmodule

// File: tb/tb_ila_core_sync.sv
// Directed bench for ila_core_sync: a sample-list model of the capture rules is compared every cycle,
// and hand-computed literals from the capture scenarios pin the model.
module tb_ila_core_sync;
    localparam int DATA_W    = 32;
    localparam int BUFFER_W  = 4;
    localparam int SIGNAL_W  = 96;
    localparam int TRIGGER_W = 2;
    localparam int VS_W      = 2;
    localparam int DEPTH     = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [SIGNAL_W-1:0]  signal;
    logic [TRIGGER_W-1:0] trigger;

    ila_core_sync_if #(.DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .TRIGGER_W(TRIGGER_W), .VS_W(VS_W)) bus ();

    ila_core_sync #(
        .DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .SIGNAL_W(SIGNAL_W), .TRIGGER_W(TRIGGER_W)
    ) dut (
        .clk(clk), .rst(rst), .signal(signal), .trigger(trigger), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: every stored sample in write order, with a "seen" flag per sticky trigger.
    logic [SIGNAL_W-1:0] mbuf [DEPTH];
    bit                  mvalid [DEPTH];
    int                  wr_total = 0;
    bit [1:0]            seen = '0;
    logic [1:0]          tprev = '0;
    logic [SIGNAL_W-1:0] sprev = '0;
    int                  exp_count = 0;
    logic [31:0]         exp_value = '0;
    bit                  value_known = 1'b0;
    bit                  chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] slice_of(input logic [SIGNAL_W-1:0] w, input int sel);
        case (sel)
            0:       return w[31:0];
            1:       return w[63:32];
            2:       return w[95:64];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_tick();
        logic [1:0]          t_now;
        logic [1:0]          t_use;
        logic [SIGNAL_W-1:0] d;
        bit                  any_on;
        bit                  all_on;
        bit                  a;
        bit                  act;
        int                  n_mask;
        if (rst) begin
            exp_value   = '0;
            value_known = 1'b1;
        end else begin
            value_known = mvalid[int'(bus.index)];
            if (value_known)
                exp_value = slice_of(mbuf[int'(bus.index)], int'(bus.value_select));
        end
        if (rst)
            for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
        if (rst || bus.rst_soft) begin
            wr_total = 0;
            seen     = '0;
            tprev    = '0;
            sprev    = '0;
        end else begin
            t_now  = trigger ^ bus.negate_trigger;
            t_use  = bus.delay_trigger ? tprev : t_now;
            any_on = 1'b0;
            all_on = 1'b1;
            n_mask = 0;
            for (int i = 0; i < 2; i++) begin
                a = t_use[i] || (!bus.trigger_type[i] && seen[i]);
                if (bus.trigger_mask[i]) begin
                    n_mask++;
                    if (a) any_on = 1'b1;
                    else   all_on = 1'b0;
                end
            end
            act = (n_mask > 0) && (bus.reduce_type ? all_on : any_on);
            d   = bus.delay_signal ? sprev : signal;
`ifdef ILA_CIRCULAR_EN
            if (act) begin
`else
            if (act && wr_total < DEPTH) begin
`endif
                mbuf[wr_total % DEPTH]   = d;
                mvalid[wr_total % DEPTH] = 1'b1;
                wr_total++;
            end
            for (int i = 0; i < 2; i++)
                if (!bus.trigger_type[i] && t_use[i]) seen[i] = 1'b1;
            tprev = t_now;
            sprev = signal;
        end
        exp_count = (wr_total < DEPTH) ? wr_total : DEPTH;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("samples", bus.samples, 32'(exp_count));
            if (value_known)
                check("value", bus.value, exp_value);
        end
    end

    task automatic step(input logic [7:0] s, input logic [1:0] tr);
        signal  = {24'h0, s + 8'd2, 24'h0, s + 8'd1, 24'h0, s};
        trigger = tr;
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic configure(input logic [1:0] ttype, input logic [1:0] mask,
                             input logic dt, input logic ds, input logic red);
        bus.trigger_type   = ttype;
        bus.negate_trigger = 2'b00;
        bus.trigger_mask   = mask;
        bus.delay_trigger  = dt;
        bus.delay_signal   = ds;
        bus.reduce_type    = red;
    endtask

    task automatic soft_clear();
        bus.rst_soft = 1'b1;
        step(8'h00, 2'b00);
        bus.rst_soft = 1'b0;
    endtask

    // Common stimulus: 0x01..0x09 then 0x10; t1 on 02/07/08, t2 on 04/06/07.
    task automatic run_pattern(input int extra);
        logic [7:0] s;
        for (int k = 0; k < 10; k++) begin
            s = (k < 9) ? 8'(k + 1) : 8'h10;
            step(s, {(s == 8'h04 || s == 8'h06 || s == 8'h07),
                     (s == 8'h02 || s == 8'h07 || s == 8'h08)});
        end
        for (int k = 0; k < extra; k++)
            step(8'h10, 2'b00);
    endtask

    task automatic read_lit(input string name, input int idx, input int sel, input logic [31:0] exp);
        bus.trigger_mask = 2'b00;
        bus.index        = 4'(idx);
        bus.value_select = 2'(sel);
        step(8'h00, 2'b00);
        check(name, bus.value, exp);
    endtask

    initial begin
        rst     = 1'b1;
        signal  = '0;
        trigger = '0;
        bus.rst_soft     = 1'b0;
        bus.index        = '0;
        bus.value_select = '0;
        configure(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 2'b00);
        #1 chk_on = 1'b1;
        step(8'h00, 2'b00);
        check("rst_samples", bus.samples, 32'h0);
        check("rst_value", bus.value, 32'h0);
        rst = 1'b0;

        // Single type on t1, OR: captures every cycle from 0x02 until full.
        configure(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        soft_clear();
        run_pattern(10);
        check("single_full_samples", bus.samples, 32'd16);
        read_lit("single_b8_s0", 8, 0, 32'h10);
        read_lit("single_b8_s1", 8, 1, 32'h11);
`ifndef ILA_CIRCULAR_EN
        read_lit("single_b0", 0, 0, 32'h02);
`endif

        configure(2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
        soft_clear();
        run_pattern(0);
        check("cont_samples", bus.samples, 32'd3);
        read_lit("cont_b0", 0, 0, 32'h02);
        read_lit("cont_b1", 1, 0, 32'h07);
        read_lit("cont_b2", 2, 0, 32'h08);
        read_lit("cont_b0_s1", 0, 1, 32'h03);
        read_lit("cont_b0_s2", 0, 2, 32'h04);
        read_lit("cont_b0_s3_zero", 0, 3, 32'h00);

        configure(2'b11, 2'b01, 1'b1, 1'b0, 1'b0);
        soft_clear();
        run_pattern(0);
        check("dtrig_samples", bus.samples, 32'd3);
        read_lit("dtrig_b0", 0, 0, 32'h03);
        read_lit("dtrig_b2", 2, 0, 32'h09);

        configure(2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        soft_clear();
        run_pattern(0);
        check("dsig_samples", bus.samples, 32'd3);
        read_lit("dsig_b0", 0, 0, 32'h01);
        read_lit("dsig_b1", 1, 0, 32'h06);

        configure(2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
        soft_clear();
        run_pattern(0);
        check("cont_and_samples", bus.samples, 32'd1);
        read_lit("cont_and_b0", 0, 0, 32'h07);

        configure(2'b11, 2'b11, 1'b0, 1'b0, 1'b0);
        soft_clear();
        run_pattern(0);
        check("cont_or_samples", bus.samples, 32'd5);
        read_lit("cont_or_b1", 1, 0, 32'h04);
        read_lit("cont_or_b4", 4, 0, 32'h08);

        configure(2'b00, 2'b11, 1'b0, 1'b0, 1'b1);
        soft_clear();
        run_pattern(0);
        check("single_and_samples", bus.samples, 32'd7);
        read_lit("single_and_b0", 0, 0, 32'h04);

        configure(2'b00, 2'b10, 1'b0, 1'b0, 1'b1);
        soft_clear();
        run_pattern(0);
        check("mask10_samples", bus.samples, 32'd7);
        read_lit("mask10_b0", 0, 0, 32'h04);

        configure(2'b10, 2'b11, 1'b0, 1'b0, 1'b1);
        soft_clear();
        run_pattern(0);
        check("mixed_and_samples", bus.samples, 32'd3);
        read_lit("mixed_b1", 1, 0, 32'h06);
        read_lit("mixed_b2", 2, 0, 32'h07);

        // Soft clear mid-capture while the trigger is high: the clear wins and the latch drops.
        configure(2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        soft_clear();
        step(8'h01, 2'b00);
        step(8'h02, 2'b01);
        step(8'h03, 2'b00);
        step(8'h04, 2'b00);
        check("pre_clear_samples", bus.samples, 32'd3);
        bus.rst_soft = 1'b1;
        step(8'h05, 2'b01);
        bus.rst_soft = 1'b0;
        check("soft_clear_samples", bus.samples, 32'd0);
        step(8'h06, 2'b00);
        check("latch_cleared", bus.samples, 32'd0);
        step(8'h07, 2'b01);
        step(8'h08, 2'b01);
        step(8'h09, 2'b00);
        step(8'h10, 2'b00);
        check("resume_samples", bus.samples, 32'd4);
        read_lit("resume_b0", 0, 0, 32'h07);

        rst = 1'b1;
        step(8'h00, 2'b00);
        rst = 1'b0;
        check("hard_rst_value", bus.value, 32'h0);
        check("hard_rst_samples", bus.samples, 32'h0);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
